qsys_system_data_mem_dp: RTL



---
 rtl/qsys_mem_pkg.sv | 19 +
 rtl/qsys_mem_rd_pipe.sv | 44 ++++
 rtl/qsys_system_data_mem_dp.sv | 117 +++++++++++
 3 files changed

// File: rtl/qsys_mem_pkg.sv
// Shared constants and byte-lane helpers for the dual-port Qsys data memory.
package qsys_mem_pkg;

    localparam int unsigned RdLatencyMin = 1;
    localparam int unsigned RdLatencyMax = 2;

    // One byte lane of a masked write: the new byte where enabled, the old byte otherwise.
    function automatic logic [7:0] merge_lane(input logic [7:0] old_byte,
                                              input logic [7:0] new_byte,
                                              input logic       en);
        return en ? new_byte : old_byte;
    endfunction

    // Port B keeps a lane only where port A is not writing the same word on that lane.
    function automatic logic collide_lane(input logic a_be, input logic b_be);
        return b_be & ~a_be;
    endfunction

endpackage

// File: rtl/qsys_mem_rd_pipe.sv
// Clock-enable gated read-return delay line: valid pulse plus data that holds between reads.
module qsys_mem_rd_pipe
    import qsys_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              ce_i,
    input  logic              rd_valid_i,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic [READ_LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]       data_q [READ_LATENCY];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else if (ce_i) begin
            valid_q[0] <= rd_valid_i;
            if (rd_valid_i) begin
                data_q[0] <= rd_data_i;
            end
            // Data only moves with its valid so the output holds between reads.
            for (int i = 1; i < READ_LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[READ_LATENCY-1];
    assign data_o  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/qsys_system_data_mem_dp.sv
// True dual-port byte-enabled data memory with two Avalon-MM slave ports, write forwarding
// on the same port, old-data cross-port reads and port-A-wins write collisions.
module qsys_system_data_mem_dp
    import qsys_mem_pkg::*;
#(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned DEPTH        = 4096,
    parameter int unsigned READ_LATENCY = 1,
    parameter string       INIT_FILE    = "",
    localparam int unsigned ADDR_W      = $clog2(DEPTH),
    localparam int unsigned BE_W        = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    input  logic              reset_req,
    input  logic              freeze,
    input  logic [ADDR_W-1:0] a_address,
    input  logic              a_chipselect,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [BE_W-1:0]   a_byteenable,
    input  logic [DATA_W-1:0] a_writedata,
    output logic [DATA_W-1:0] a_readdata,
    output logic              a_readdatavalid,
    input  logic [ADDR_W-1:0] b_address,
    input  logic              b_chipselect,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [BE_W-1:0]   b_byteenable,
    input  logic [DATA_W-1:0] b_writedata,
    output logic [DATA_W-1:0] b_readdata,
    output logic              b_readdatavalid
);

    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $fatal(1, "qsys_system_data_mem_dp: DATA_W must be a non-zero multiple of 8");
    end
    if (READ_LATENCY < RdLatencyMin || READ_LATENCY > RdLatencyMax) begin : g_bad_latency
        $fatal(1, "qsys_system_data_mem_dp: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "qsys_system_data_mem_dp: DEPTH must be a power of two, at least 16");
    end
    if (INIT_FILE != "") begin : g_init_note
        $info("qsys_system_data_mem_dp: INIT_FILE preload is applied by the device memory flow");
    end

    logic              ce;
    logic              a_we, b_we, a_re, b_re, same_word;
    logic [BE_W-1:0]   a_lane_we, b_lane_we;
    logic [DATA_W-1:0] a_old, b_old, a_rd_data, b_rd_data;
    logic [DATA_W-1:0] mem [DEPTH];

    assign ce        = clken & ~reset_req;
    assign a_we      = a_chipselect & a_write & ce & ~freeze;
    assign b_we      = b_chipselect & b_write & ce & ~freeze;
    assign a_re      = a_chipselect & a_read & ce;
    assign b_re      = b_chipselect & b_read & ce;
    assign same_word = (a_address == b_address);
    assign a_old     = mem[a_address];
    assign b_old     = mem[b_address];

    // Each port forwards only its own write; the other port's write is seen next access.
    always_comb begin
        a_lane_we = '0;
        b_lane_we = '0;
        a_rd_data = a_old;
        b_rd_data = b_old;
        for (int i = 0; i < BE_W; i++) begin
            a_lane_we[i] = a_we & a_byteenable[i];
            b_lane_we[i] = collide_lane(a_lane_we[i] & same_word, b_we & b_byteenable[i]);
            a_rd_data[i*8 +: 8] = merge_lane(a_old[i*8 +: 8], a_writedata[i*8 +: 8],
                                             a_lane_we[i]);
            b_rd_data[i*8 +: 8] = merge_lane(b_old[i*8 +: 8], b_writedata[i*8 +: 8],
                                             b_we & b_byteenable[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (a_lane_we[i]) begin
                mem[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
            end
            if (b_lane_we[i]) begin
                mem[b_address][i*8 +: 8] <= b_writedata[i*8 +: 8];
            end
        end
    end

    qsys_mem_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_a (
        .clk_i      (clk),
        .reset_i    (reset),
        .ce_i       (ce),
        .rd_valid_i (a_re),
        .rd_data_i  (a_rd_data),
        .valid_o    (a_readdatavalid),
        .data_o     (a_readdata)
    );

    qsys_mem_rd_pipe #(
        .DATA_W       (DATA_W),
        .READ_LATENCY (READ_LATENCY)
    ) u_rd_pipe_b (
        .clk_i      (clk),
        .reset_i    (reset),
        .ce_i       (ce),
        .rd_valid_i (b_re),
        .rd_data_i  (b_rd_data),
        .valid_o    (b_readdatavalid),
        .data_o     (b_readdata)
    );

endmodule
